// File: rtl/ycc_pkg.sv
// Shared constants for the YCbCr->RGB converter: matrix tables, offsets, mode bit positions.
package ycc_pkg;
    localparam int LAT      = 4;
    localparam int MODE_MAT = 0;
    localparam int MODE_RNG = 1;
    localparam int MODE_BYP = 2;
    localparam int CW       = 11;

    // Unsigned Q3.8 coefficients; G uses gcr/gcb as subtrahends.
    typedef struct packed {
        logic [CW-1:0] ky;
        logic [CW-1:0] rcr;
        logic [CW-1:0] gcr;
        logic [CW-1:0] gcb;
        logic [CW-1:0] bcb;
    } coef_t;

    localparam coef_t COEF_601L = '{ky: 11'd298, rcr: 11'd409, gcr: 11'd208, gcb: 11'd100, bcb: 11'd516};
    localparam coef_t COEF_709L = '{ky: 11'd298, rcr: 11'd459, gcr: 11'd136, gcb: 11'd55,  bcb: 11'd541};
    localparam coef_t COEF_601F = '{ky: 11'd256, rcr: 11'd359, gcr: 11'd183, gcb: 11'd88,  bcb: 11'd454};
    localparam coef_t COEF_709F = '{ky: 11'd256, rcr: 11'd403, gcr: 11'd120, gcb: 11'd48,  bcb: 11'd475};

    // mode = {range, matrix}
    function automatic coef_t coef_sel(input logic [1:0] mode);
        coef_t c;
        case (mode)
            2'b00:   c = COEF_601L;
            2'b01:   c = COEF_709L;
            2'b10:   c = COEF_601F;
            default: c = COEF_709F;
        endcase
        return c;
    endfunction

    function automatic int y_off(input int dw);
        return 16 << (dw - 8);
    endfunction

    function automatic int c_off(input int dw);
        return 1 << (dw - 1);
    endfunction
endpackage

// File: rtl/ycc_clip.sv
// Combinational saturate of a signed value into the unsigned range [0, 2^DW-1].
// No state, no latency, no flow control.
module ycc_clip #(
    parameter int IW = 12,
    parameter int DW = 8
) (
    input  logic signed [IW-1:0] din,
    output logic        [DW-1:0] dout
);
    localparam logic signed [IW-1:0] MAXV = IW'((1 << DW) - 1);

    always_comb begin
        if (din[IW-1])
            dout = '0;
        else if (din > MAXV)
            dout = '1;
        else
            dout = din[DW-1:0];
    end
endmodule

// File: rtl/ycbcr2rgb_pipe.sv
// YCbCr 4:4:4 -> RGB, 4-stage pipeline, one pixel per clock, no backpressure.
// Mode/bypass latched on frame start and carried with every pixel; sideband delayed 4 clocks unconditionally.
module ycbcr2rgb_pipe
    import ycc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int SYNC_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        i_mode,
    input  logic              i_bypass,
    input  logic              i_frame_start,
    input  logic              i_valid,
    input  logic [DW-1:0]     i_y,
    input  logic [DW-1:0]     i_cb,
    input  logic [DW-1:0]     i_cr,
    input  logic [SYNC_W-1:0] i_sync,
    output logic              o_valid,
    output logic [DW-1:0]     o_r,
    output logic [DW-1:0]     o_g,
    output logic [DW-1:0]     o_b,
    output logic [SYNC_W-1:0] o_sync,
    output logic [2:0]        o_mode_act
);
    localparam int SW = DW + 1;
    localparam int PW = DW + 12;
    localparam int RW = DW + 4;
    localparam logic [SW-1:0]        Y_OFF = SW'(y_off(DW));
    localparam logic [SW-1:0]        C_OFF = SW'(c_off(DW));
    localparam logic signed [PW-1:0] RND   = PW'(128);

    logic [2:0] act_mode, pix_mode;
    // A frame-start pixel already uses the mode presented with it.
    assign pix_mode = i_frame_start ? {i_bypass, i_mode} : act_mode;

    logic                 v1, v2, v3;
    logic [2:0]           m1, m2, m3;
    coef_t                k1;
    logic signed [SW-1:0] y1, cb1, cr1;
    logic [DW-1:0]        raw_y1, raw_cb1, raw_cr1, raw_y2, raw_cb2, raw_cr2;
    logic signed [PW-1:0] p_y, p_rcr, p_gcr, p_gcb, p_bcb;
    logic signed [PW-1:0] s_r, s_g, s_b;
    logic signed [RW-1:0] r3, g3, b3;
    logic [DW-1:0]        r_clip, g_clip, b_clip;
    logic [SYNC_W-1:0]    sync_dly [LAT];

    always_comb begin
        s_r = p_y + p_rcr + RND;
        s_g = p_y - p_gcr - p_gcb + RND;
        s_b = p_y + p_bcb + RND;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_mode   <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            o_valid    <= 1'b0;
            m1         <= '0;
            m2         <= '0;
            m3         <= '0;
            k1         <= '0;
            y1         <= '0;
            cb1        <= '0;
            cr1        <= '0;
            raw_y1     <= '0;
            raw_cb1    <= '0;
            raw_cr1    <= '0;
            raw_y2     <= '0;
            raw_cb2    <= '0;
            raw_cr2    <= '0;
            p_y        <= '0;
            p_rcr      <= '0;
            p_gcr      <= '0;
            p_gcb      <= '0;
            p_bcb      <= '0;
            r3         <= '0;
            g3         <= '0;
            b3         <= '0;
            o_r        <= '0;
            o_g        <= '0;
            o_b        <= '0;
            o_mode_act <= '0;
            for (int i = 0; i < LAT; i++) sync_dly[i] <= '0;
        end else begin
            if (i_frame_start) act_mode <= {i_bypass, i_mode};
            v1      <= i_valid;
            v2      <= v1;
            v3      <= v2;
            o_valid <= v3;
            sync_dly[0] <= i_sync;
            for (int i = 1; i < LAT; i++) sync_dly[i] <= sync_dly[i-1];

            if (i_valid) begin
                m1      <= pix_mode;
                k1      <= coef_sel(pix_mode[1:0]);
                y1      <= pix_mode[MODE_RNG] ? {1'b0, i_y} : {1'b0, i_y} - Y_OFF;
                cb1     <= {1'b0, i_cb} - C_OFF;
                cr1     <= {1'b0, i_cr} - C_OFF;
                raw_y1  <= i_y;
                raw_cb1 <= i_cb;
                raw_cr1 <= i_cr;
            end

            if (v1) begin
                m2      <= m1;
                p_y     <= PW'(y1)  * PW'($signed({1'b0, k1.ky}));
                p_rcr   <= PW'(cr1) * PW'($signed({1'b0, k1.rcr}));
                p_gcr   <= PW'(cr1) * PW'($signed({1'b0, k1.gcr}));
                p_gcb   <= PW'(cb1) * PW'($signed({1'b0, k1.gcb}));
                p_bcb   <= PW'(cb1) * PW'($signed({1'b0, k1.bcb}));
                raw_y2  <= raw_y1;
                raw_cb2 <= raw_cb1;
                raw_cr2 <= raw_cr1;
            end

            // Bypass values are zero-extended, so the clip stage passes them untouched.
            if (v2) begin
                m3 <= m2;
                if (m2[MODE_BYP]) begin
                    r3 <= RW'(raw_cr2);
                    g3 <= RW'(raw_y2);
                    b3 <= RW'(raw_cb2);
                end else begin
                    r3 <= RW'(s_r >>> 8);
                    g3 <= RW'(s_g >>> 8);
                    b3 <= RW'(s_b >>> 8);
                end
            end

            if (v3) begin
                o_r        <= r_clip;
                o_g        <= g_clip;
                o_b        <= b_clip;
                o_mode_act <= m3;
            end
        end
    end

    assign o_sync = sync_dly[LAT-1];

    ycc_clip #(.IW(RW), .DW(DW)) u_clip_r (.din(r3), .dout(r_clip));
    ycc_clip #(.IW(RW), .DW(DW)) u_clip_g (.din(g3), .dout(g_clip));
    ycc_clip #(.IW(RW), .DW(DW)) u_clip_b (.din(b3), .dout(b_clip));
endmodule
